cpu_test_monitor: RTL and testbench

Synthesizable, parametrised test-status monitor that snoops the CPU/memory bus and CPU status outputs. It collects per-test pass/fail results written to a mailbox address, detects the halt word, enforces a cycle watchdog, and optionally keeps a PC trace ring. It sits beside `CPU_top`/`memory_top` in simulation and on-board builds, replacing per-test `$display` checking with hardware status outputs.

---
 rtl/cpu_test_monitor_if.sv | 46 ++++
 rtl/cpu_test_monitor.sv | 226 ++++++++++++++++++++++
 tb/tb_cpu_test_monitor.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_test_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_test_monitor_if
// Description : Snoop bundle carrying the CPU output bus and the CPU status
//               signals watched by cpu_test_monitor.
//               master - CPU side, drives every signal
//               slave  - monitor side, observes every signal
// Signals     : bus_address   [31:0] CPU output bus address
//               bus_data      [31:0] CPU output bus write data
//               bus_DV               CPU bus request valid
//               write_notread        1 = write, 0 = read
//               state         [31:0] CPU FSM state, 0 = fetch
//               PC            [31:0] CPU program counter
//               instruction   [31:0] instruction currently executing
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_test_monitor_if;
  logic [31:0] bus_address;
  logic [31:0] bus_data;
  logic        bus_DV;
  logic        write_notread;
  logic [31:0] state;
  logic [31:0] PC;
  logic [31:0] instruction;

  modport master (
    output bus_address,
    output bus_data,
    output bus_DV,
    output write_notread,
    output state,
    output PC,
    output instruction
  );

  modport slave (
    input bus_address,
    input bus_data,
    input bus_DV,
    input write_notread,
    input state,
    input PC,
    input instruction
  );
endinterface
`default_nettype wire

// File: rtl/cpu_test_monitor.sv
`default_nettype none
// ============================================================================
// Module      : cpu_test_monitor
// Description : Snoops the CPU bus and status signals. Collects per-test
//               pass/fail results written to a mailbox address, detects the
//               halt instruction, runs a cycle watchdog and optionally keeps
//               a ring of PCs recorded on every entry into fetch.
// Option      : define CPU_TEST_MONITOR_TRACE_EN to build the PC trace ring;
//               otherwise o_trace_pc / o_trace_count are tied to 0.
// Ports       : i_clk          clock
//               i_rst_n        synchronous active-low reset
//               bus            snooped CPU bus / status (slave modport)
//               i_trace_idx    trace read index, 0 = most recent entry
//               o_test_pass    per-test pass bitmap
//               o_test_fail    per-test fail bitmap
//               o_bad_index    sticky, mailbox index out of range seen
//               o_running      monitor in RUN
//               o_done         halt instruction seen
//               o_timeout      watchdog fired
//               o_all_pass     done, expected tests passed, nothing failed
//               o_cycles       RUN cycle count (saturating)
//               o_halt_pc      PC captured on the halt
//               o_trace_pc     trace read data (1-cycle latency)
//               o_trace_count  number of valid trace entries
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_test_monitor #(
  parameter int                  NUM_TESTS      = 64,
  parameter logic [31:0]         MAILBOX_ADDR   = 32'hFFFF_0100,
  parameter logic [31:0]         HALT_WORD      = 32'd255,
  parameter int                  TIMEOUT_CYCLES = 1_000_000,
  parameter int                  CYCLE_W        = 32,
  parameter logic [NUM_TESTS-1:0] EXPECT_MASK   = '1,
  parameter int                  TRACE_DEPTH    = 16
) (
  input  wire logic                            i_clk,
  input  wire logic                            i_rst_n,
  cpu_test_monitor_if.slave                    bus,
  input  wire logic [$clog2(TRACE_DEPTH)-1:0]  i_trace_idx,
  output logic      [NUM_TESTS-1:0]            o_test_pass,
  output logic      [NUM_TESTS-1:0]            o_test_fail,
  output logic                                 o_bad_index,
  output logic                                 o_running,
  output logic                                 o_done,
  output logic                                 o_timeout,
  output logic                                 o_all_pass,
  output logic      [CYCLE_W-1:0]              o_cycles,
  output logic      [31:0]                     o_halt_pc,
  output logic      [31:0]                     o_trace_pc,
  output logic      [$clog2(TRACE_DEPTH):0]    o_trace_count
);

  localparam int                 c_IDX_W        = $clog2(TRACE_DEPTH);
  localparam int                 c_CNT_W        = c_IDX_W + 1;
  localparam logic [CYCLE_W-1:0] c_CYC_MAX      = '1;
  // The watchdog fires on the edge where the count already reads T-1, which
  // is exactly TIMEOUT_CYCLES edges after the edge that entered RUN.
  localparam logic [CYCLE_W-1:0] c_TIMEOUT_LAST = CYCLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t               r_state;
  logic [NUM_TESTS-1:0] r_pass;
  logic [NUM_TESTS-1:0] r_fail;
  logic                 r_bad_index;
  logic                 r_running;
  logic                 r_done;
  logic                 r_timeout;
  logic [CYCLE_W-1:0]   r_cycles;
  logic [31:0]          r_halt_pc;

  logic                 w_active;
  logic                 w_mbox_wr;
  logic [15:0]          w_idx;
  logic                 w_idx_ok;
  logic                 w_is_pass;
  logic                 w_halt;
  logic [NUM_TESTS-1:0] w_sel;

  // Results are only accepted before the run has reached a terminal state.
  assign w_active  = (r_state == S_IDLE) || (r_state == S_RUN);
  assign w_mbox_wr = bus.bus_DV && bus.write_notread &&
                     (bus.bus_address == MAILBOX_ADDR) && w_active;
  assign w_idx     = bus.bus_data[15:0];
  assign w_is_pass = bus.bus_data[31];
  assign w_idx_ok  = ({16'd0, w_idx} < 32'(NUM_TESTS));
  assign w_halt    = (bus.instruction == HALT_WORD);

  // One-hot select of the reported test; all zero for out-of-range indices.
  always_comb begin
    w_sel = '0;
    for (int t = 0; t < NUM_TESTS; t++) begin
      w_sel[t] = (w_idx == 16'(t));
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_pass      <= '0;
      r_fail      <= '0;
      r_bad_index <= 1'b0;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_cycles    <= '0;
      r_halt_pc   <= '0;
    end else begin
      if (w_mbox_wr) begin
        if (w_idx_ok) begin
          if (w_is_pass) begin
            r_pass <= r_pass | w_sel;
            r_fail <= r_fail & ~w_sel;
          end else begin
            r_fail <= r_fail | w_sel;
            r_pass <= r_pass & ~w_sel;
          end
        end else begin
          r_bad_index <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (bus.bus_DV) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        S_RUN: begin
          // Every cycle spent in RUN is counted, including the one that
          // leaves it; the count then stays frozen.
          if (r_cycles != c_CYC_MAX) begin
            r_cycles <= r_cycles + 1'b1;
          end
          // Halt has priority over a watchdog expiring on the same edge.
          if (w_halt) begin
            r_state   <= S_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_halt_pc <= bus.PC;
          end else if (r_cycles == c_TIMEOUT_LAST) begin
            r_state   <= S_TIMEOUT;
            r_running <= 1'b0;
            r_timeout <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_test_pass = r_pass;
  assign o_test_fail = r_fail;
  assign o_bad_index = r_bad_index;
  assign o_running   = r_running;
  assign o_done      = r_done;
  assign o_timeout   = r_timeout;
  assign o_cycles    = r_cycles;
  assign o_halt_pc   = r_halt_pc;
  assign o_all_pass  = r_done && ((r_pass & EXPECT_MASK) == EXPECT_MASK) &&
                       (r_fail == '0);

`ifdef CPU_TEST_MONITOR_TRACE_EN
  logic [31:0]        r_trace_mem [TRACE_DEPTH];
  logic [c_IDX_W-1:0] r_wptr;
  logic [c_CNT_W-1:0] r_tcount;
  logic               r_last_nz;
  logic [31:0]        r_trace_pc;

  logic               w_fetch_entry;
  logic [c_IDX_W-1:0] w_rd_ptr;
  logic               w_rd_valid;

  // A fetch entry is the first cycle of state 0 after any non-fetch state.
  assign w_fetch_entry = (r_state == S_RUN) && (bus.state == 32'd0) && r_last_nz;
  // Pointer arithmetic wraps naturally at the power-of-two depth.
  assign w_rd_ptr      = r_wptr - c_IDX_W'(1) - i_trace_idx;
  assign w_rd_valid    = ({1'b0, i_trace_idx} < r_tcount);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr     <= '0;
      r_tcount   <= '0;
      r_last_nz  <= 1'b0;
      r_trace_pc <= '0;
    end else begin
      r_last_nz <= (bus.state != 32'd0);
      if (w_fetch_entry) begin
        r_wptr <= r_wptr + 1'b1;
        if (r_tcount != c_CNT_W'(TRACE_DEPTH)) begin
          r_tcount <= r_tcount + 1'b1;
        end
      end
      r_trace_pc <= w_rd_valid ? r_trace_mem[w_rd_ptr] : 32'd0;
    end
  end

  // Storage is not reset: unwritten slots are masked by the entry count.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_fetch_entry) begin
      r_trace_mem[r_wptr] <= bus.PC;
    end
  end

  assign o_trace_pc    = r_trace_pc;
  assign o_trace_count = r_tcount;

  logic w_unused_bits;
  assign w_unused_bits = ^bus.bus_data[30:16];
`else
  assign o_trace_pc    = '0;
  assign o_trace_count = '0;

  logic w_unused_bits;
  assign w_unused_bits = ^{bus.bus_data[30:16], bus.state, i_trace_idx};
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_test_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_test_monitor
// Description : Self-checking bench for cpu_test_monitor. Expected values are
//               queued as each stimulus step is applied and compared against
//               the DUT once that step's edge has been taken.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_test_monitor;

  localparam int          NT   = 64;
  localparam int          TD   = 4;
  localparam int          IW   = 2;
  localparam logic [31:0] MBOX = 32'hFFFF_0100;

  localparam int SEL_PASS    = 0;
  localparam int SEL_FAIL    = 1;
  localparam int SEL_BAD     = 2;
  localparam int SEL_RUNNING = 3;
  localparam int SEL_DONE    = 4;
  localparam int SEL_TIMEOUT = 5;
  localparam int SEL_ALLPASS = 6;
  localparam int SEL_CYCLES  = 7;
  localparam int SEL_HALTPC  = 8;
  localparam int SEL_TRPC    = 9;
  localparam int SEL_TRCNT   = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [IW-1:0] trace_idx;
  logic [NT-1:0] test_pass;
  logic [NT-1:0] test_fail;
  logic          bad_index;
  logic          running;
  logic          done;
  logic          timeout;
  logic          all_pass;
  logic [31:0]   cycles;
  logic [31:0]   halt_pc;
  logic [31:0]   trace_pc;
  logic [IW:0]   trace_count;

  cpu_test_monitor_if u_bus();

  cpu_test_monitor #(
    .NUM_TESTS      (NT),
    .MAILBOX_ADDR   (MBOX),
    .HALT_WORD      (32'd255),
    .TIMEOUT_CYCLES (100),
    .CYCLE_W        (32),
    .EXPECT_MASK    (64'h28),
    .TRACE_DEPTH    (TD)
  ) u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .bus           (u_bus),
    .i_trace_idx   (trace_idx),
    .o_test_pass   (test_pass),
    .o_test_fail   (test_fail),
    .o_bad_index   (bad_index),
    .o_running     (running),
    .o_done        (done),
    .o_timeout     (timeout),
    .o_all_pass    (all_pass),
    .o_cycles      (cycles),
    .o_halt_pc     (halt_pc),
    .o_trace_pc    (trace_pc),
    .o_trace_count (trace_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      SEL_PASS:    return test_pass;
      SEL_FAIL:    return test_fail;
      SEL_BAD:     return {63'd0, bad_index};
      SEL_RUNNING: return {63'd0, running};
      SEL_DONE:    return {63'd0, done};
      SEL_TIMEOUT: return {63'd0, timeout};
      SEL_ALLPASS: return {63'd0, all_pass};
      SEL_CYCLES:  return {32'd0, cycles};
      SEL_HALTPC:  return {32'd0, halt_pc};
      SEL_TRPC:    return {32'd0, trace_pc};
      SEL_TRCNT:   return {61'd0, trace_count};
      default:     return '1;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    u_bus.bus_DV        = 1'b0;
    u_bus.write_notread = 1'b0;
    u_bus.bus_address   = 32'd0;
    u_bus.bus_data      = 32'd0;
  endtask

  task automatic mbox(input logic [31:0] d);
    u_bus.bus_DV        = 1'b1;
    u_bus.write_notread = 1'b1;
    u_bus.bus_address   = MBOX;
    u_bus.bus_data      = d;
    step();
    bus_idle();
  endtask

  task automatic enter_run();
    u_bus.bus_DV        = 1'b1;
    u_bus.write_notread = 1'b0;
    u_bus.bus_address   = 32'h0000_1000;
    step();
    bus_idle();
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    bus_idle();
    u_bus.instruction = 32'd0;
    u_bus.state       = 32'd1;
    u_bus.PC          = 32'd0;
    step();
    rst_n             = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    trace_idx = '0;
    do_reset();
    do_reset();
    expect_val("rst_running", SEL_RUNNING, 0);
    expect_val("rst_done",    SEL_DONE,    0);
    expect_val("rst_timeout", SEL_TIMEOUT, 0);
    expect_val("rst_cycles",  SEL_CYCLES,  0);
    expect_val("rst_pass",    SEL_PASS,    0);
    expect_val("rst_fail",    SEL_FAIL,    0);
    expect_val("rst_bad",     SEL_BAD,     0);
    expect_val("rst_allpass", SEL_ALLPASS, 0);
    expect_val("rst_haltpc",  SEL_HALTPC,  0);
    expect_val("rst_trcnt",   SEL_TRCNT,   0);
    drain();

    // One bus read enters RUN, then ten idle cycles are counted.
    enter_run();
    expect_val("entry_running", SEL_RUNNING, 1);
    expect_val("entry_cycles",  SEL_CYCLES,  0);
    drain();
    repeat (10) step();
    expect_val("run10_running", SEL_RUNNING, 1);
    expect_val("run10_cycles",  SEL_CYCLES,  10);
    expect_val("run10_pass",    SEL_PASS,    0);
    expect_val("run10_fail",    SEL_FAIL,    0);
    drain();

    // Mailbox results, last write per index wins.
    mbox(32'h8000_0003);
    expect_val("mb1_pass", SEL_PASS, 64'h8);
    expect_val("mb1_fail", SEL_FAIL, 64'h0);
    drain();
    mbox(32'h0000_0005);
    expect_val("mb2_pass", SEL_PASS, 64'h8);
    expect_val("mb2_fail", SEL_FAIL, 64'h20);
    drain();
    mbox(32'h8000_0005);
    expect_val("mb3_pass", SEL_PASS, 64'h28);
    expect_val("mb3_fail", SEL_FAIL, 64'h0);
    drain();
    mbox(32'h8000_0050);
    expect_val("bad_flag",    SEL_BAD,     1);
    expect_val("bad_pass",    SEL_PASS,    64'h28);
    expect_val("bad_fail",    SEL_FAIL,    64'h0);
    expect_val("bad_cycles",  SEL_CYCLES,  14);
    expect_val("bad_allpass", SEL_ALLPASS, 0);
    drain();

    // Halt word ends the run and captures the PC.
    u_bus.instruction = 32'd255;
    u_bus.PC          = 32'h8000_1234;
    step();
    u_bus.instruction = 32'd0;
    u_bus.PC          = 32'd0;
    expect_val("halt_done",    SEL_DONE,    1);
    expect_val("halt_running", SEL_RUNNING, 0);
    expect_val("halt_pc",      SEL_HALTPC,  32'h8000_1234);
    expect_val("halt_allpass", SEL_ALLPASS, 1);
    expect_val("halt_timeout", SEL_TIMEOUT, 0);
    expect_val("halt_cycles",  SEL_CYCLES,  15);
    drain();
    mbox(32'h0000_0003);
    expect_val("post_pass",    SEL_PASS,    64'h28);
    expect_val("post_fail",    SEL_FAIL,    64'h0);
    expect_val("post_allpass", SEL_ALLPASS, 1);
    drain();
    repeat (120) step();
    expect_val("post_timeout", SEL_TIMEOUT, 0);
    expect_val("post_cycles",  SEL_CYCLES,  15);
    expect_val("post_done",    SEL_DONE,    1);
    drain();

    // Watchdog fires exactly 100 edges after RUN entry.
    do_reset();
    enter_run();
    repeat (99) step();
    expect_val("wd99_timeout", SEL_TIMEOUT, 0);
    expect_val("wd99_running", SEL_RUNNING, 1);
    expect_val("wd99_cycles",  SEL_CYCLES,  99);
    drain();
    step();
    expect_val("wd100_timeout", SEL_TIMEOUT, 1);
    expect_val("wd100_running", SEL_RUNNING, 0);
    expect_val("wd100_done",    SEL_DONE,    0);
    expect_val("wd100_cycles",  SEL_CYCLES,  100);
    drain();
    repeat (5) step();
    mbox(32'h8000_0001);
    expect_val("wd_frozen_cycles", SEL_CYCLES,  100);
    expect_val("wd_ignored_pass",  SEL_PASS,    0);
    expect_val("wd_still_timeout", SEL_TIMEOUT, 1);
    drain();

    // Halt and watchdog on the same edge: halt wins.
    do_reset();
    enter_run();
    repeat (99) step();
    u_bus.instruction = 32'd255;
    u_bus.PC          = 32'h0000_0044;
    step();
    u_bus.instruction = 32'd0;
    u_bus.PC          = 32'd0;
    expect_val("tie_done",    SEL_DONE,    1);
    expect_val("tie_timeout", SEL_TIMEOUT, 0);
    expect_val("tie_haltpc",  SEL_HALTPC,  32'h44);
    expect_val("tie_allpass", SEL_ALLPASS, 0);
    drain();

    // Reset in the middle of a run with results recorded.
    do_reset();
    enter_run();
    mbox(32'h8000_0003);
    mbox(32'h8000_0005);
    mbox(32'h0000_0007);
    mbox(32'h8000_0099);
    repeat (5) step();
    expect_val("mid_pass",    SEL_PASS,    64'h28);
    expect_val("mid_fail",    SEL_FAIL,    64'h80);
    expect_val("mid_bad",     SEL_BAD,     1);
    expect_val("mid_running", SEL_RUNNING, 1);
    expect_val("mid_cycles",  SEL_CYCLES,  9);
    drain();
    do_reset();
    expect_val("mrst_pass",    SEL_PASS,    0);
    expect_val("mrst_fail",    SEL_FAIL,    0);
    expect_val("mrst_bad",     SEL_BAD,     0);
    expect_val("mrst_running", SEL_RUNNING, 0);
    expect_val("mrst_cycles",  SEL_CYCLES,  0);
    drain();
    repeat (3) step();
    expect_val("mrst_idle_running", SEL_RUNNING, 0);
    expect_val("mrst_idle_cycles",  SEL_CYCLES,  0);
    drain();

    // Trace ring: six fetch entries into a four-deep ring.
    do_reset();
    enter_run();
    for (int k = 0; k < 6; k++) begin
      u_bus.state = 32'd1;
      step();
      u_bus.state = 32'd0;
      u_bus.PC    = 32'(4 * k);
      step();
    end
    u_bus.state = 32'd1;
    u_bus.PC    = 32'd0;
    step();
`ifdef CPU_TEST_MONITOR_TRACE_EN
    expect_val("tr_count", SEL_TRCNT, 4);
`else
    expect_val("tr_count", SEL_TRCNT, 0);
`endif
    drain();
    trace_idx = 2'd0;
    step();
`ifdef CPU_TEST_MONITOR_TRACE_EN
    expect_val("tr_idx0", SEL_TRPC, 32'h14);
`else
    expect_val("tr_idx0", SEL_TRPC, 0);
`endif
    drain();
    trace_idx = 2'd3;
    step();
`ifdef CPU_TEST_MONITOR_TRACE_EN
    expect_val("tr_idx3", SEL_TRPC, 32'h8);
`else
    expect_val("tr_idx3", SEL_TRPC, 0);
`endif
    drain();
    trace_idx = 2'd1;
    step();
`ifdef CPU_TEST_MONITOR_TRACE_EN
    expect_val("tr_idx1", SEL_TRPC, 32'h10);
`else
    expect_val("tr_idx1", SEL_TRPC, 0);
`endif
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
